// File: rtl/env_acc.sv
// Windowed envelope accumulator: after a sync-triggered delay, reduces each
// window of N valid samples to one value (max-|x|, mean-|x|, first, peak-to-peak, last).
module env_acc #(
  parameter int DW  = 12,
  parameter int AW  = 8,
  parameter int DLW = 16,
  parameter int LW  = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_sync,
  input  logic [DW-1:0]  i_in_data,
  input  logic           i_in_vld,
  input  logic [DLW-1:0] i_delay,
  input  logic [AW-1:0]  i_accum,
  input  logic [4:0]     i_shift,
  input  logic [LW-1:0]  i_len,
  input  logic [2:0]     i_scan_type,
  output logic [DW-1:0]  o_out_data,
  output logic           o_out_vld,
  output logic           o_busy,
  output logic           o_done
);

  localparam int SW = DW + AW;
  localparam logic [DW-1:0] POS_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [SW-1:0] MEAN_MAX = {{(AW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic [DW:0]   PP_MAX   = {2'b00, {(DW-1){1'b1}}};

  localparam logic [2:0] M_MAX   = 3'd0;
  localparam logic [2:0] M_MEAN  = 3'd1;
  localparam logic [2:0] M_FIRST = 3'd2;
  localparam logic [2:0] M_PP    = 3'd3;
  localparam logic [2:0] M_LAST  = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ACCUM} state_t;

  state_t                state_reg;
  logic [DLW-1:0]        delay_reg;
  logic [AW-1:0]         n_reg;
  logic [4:0]            shift_reg;
  logic [LW-1:0]         len_reg;
  logic [2:0]            mode_reg;
  logic [DLW-1:0]        dly_cnt_reg;
  logic [AW-1:0]         win_cnt_reg;
  logic [LW-1:0]         out_cnt_reg;
  logic signed [DW-1:0]  max_val_reg;
  logic [DW-1:0]         max_abs_reg;
  logic [SW-1:0]         sum_reg;
  logic signed [DW-1:0]  first_reg;
  logic signed [DW-1:0]  min_reg;
  logic signed [DW-1:0]  max_reg;
  logic [DW-1:0]         out_data_reg;
  logic                  out_vld_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic signed [DW-1:0]  x;
  logic [DW-1:0]         abs_x;
  logic                  win_first;
  logic                  take_new;
  logic [DW-1:0]         max_abs_next;
  logic signed [DW-1:0]  max_val_next;
  logic [SW-1:0]         sum_next;
  logic signed [DW-1:0]  min_next;
  logic signed [DW-1:0]  max_next;
  logic signed [DW-1:0]  first_next;
  logic [SW-1:0]         mean_shifted;
  logic [DW-1:0]         mean_res;
  logic [DW:0]           pp_diff;
  logic [DW-1:0]         pp_res;
  logic [DW-1:0]         result_next;
  logic                  res_ok;
  logic [DLW-1:0]        dly_inc;
  logic [AW-1:0]         win_inc;
  logic [LW-1:0]         out_inc;
  logic                  win_last;
  logic                  frame_end;

  assign x = i_in_data;

  // Magnitude kept unsigned so the most negative sample maps to 2^(DW-1) exactly.
  always_comb begin
    abs_x        = x[DW-1] ? (~i_in_data + DW'(1)) : i_in_data;
    win_first    = (win_cnt_reg == '0);
    take_new     = win_first || (abs_x > max_abs_reg);
    max_abs_next = take_new ? abs_x : max_abs_reg;
    max_val_next = take_new ? x : max_val_reg;
    sum_next     = (win_first ? '0 : sum_reg) + SW'(abs_x);
    min_next     = (win_first || (x < min_reg)) ? x : min_reg;
    max_next     = (win_first || (x > max_reg)) ? x : max_reg;
    first_next   = win_first ? x : first_reg;

    mean_shifted = sum_next >> shift_reg;
    mean_res     = (mean_shifted > MEAN_MAX) ? POS_MAX : mean_shifted[DW-1:0];

    // max >= min always, so the DW+1-bit difference is non-negative.
    pp_diff      = {max_next[DW-1], max_next} - {min_next[DW-1], min_next};
    pp_res       = (pp_diff > PP_MAX) ? POS_MAX : pp_diff[DW-1:0];

    res_ok       = 1'b1;
    case (mode_reg)
      M_MAX:   result_next = max_val_next;
      M_MEAN:  result_next = mean_res;
      M_FIRST: result_next = first_next;
      M_PP:    result_next = pp_res;
      M_LAST:  result_next = x;
      default: begin
        result_next = out_data_reg;
        res_ok      = 1'b0;
      end
    endcase

    dly_inc   = dly_cnt_reg + DLW'(1);
    win_inc   = win_cnt_reg + AW'(1);
    out_inc   = out_cnt_reg + LW'(1);
    win_last  = (win_inc == n_reg);
    frame_end = (len_reg != '0) && (out_inc == len_reg);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      delay_reg    <= '0;
      n_reg        <= '0;
      shift_reg    <= '0;
      len_reg      <= '0;
      mode_reg     <= '0;
      dly_cnt_reg  <= '0;
      win_cnt_reg  <= '0;
      out_cnt_reg  <= '0;
      max_val_reg  <= '0;
      max_abs_reg  <= '0;
      sum_reg      <= '0;
      first_reg    <= '0;
      min_reg      <= '0;
      max_reg      <= '0;
      out_data_reg <= '0;
      out_vld_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      out_vld_reg <= 1'b0;
      done_reg    <= 1'b0;
      if (i_sync) begin
        // Restart always wins, including over a window completing this cycle.
        delay_reg   <= i_delay;
        n_reg       <= (i_accum == '0) ? AW'(1) : i_accum;
        shift_reg   <= i_shift;
        len_reg     <= i_len;
        mode_reg    <= i_scan_type;
        dly_cnt_reg <= '0;
        win_cnt_reg <= '0;
        out_cnt_reg <= '0;
        max_val_reg <= '0;
        max_abs_reg <= '0;
        sum_reg     <= '0;
        first_reg   <= '0;
        min_reg     <= '0;
        max_reg     <= '0;
        busy_reg    <= 1'b1;
        state_reg   <= (i_delay == '0) ? S_ACCUM : S_DELAY;
      end else begin
        case (state_reg)
          S_DELAY: begin
            if (i_in_vld) begin
              dly_cnt_reg <= dly_inc;
              if (dly_inc == delay_reg) state_reg <= S_ACCUM;
            end
          end
          S_ACCUM: begin
            if (i_in_vld) begin
              max_val_reg <= max_val_next;
              max_abs_reg <= max_abs_next;
              sum_reg     <= sum_next;
              first_reg   <= first_next;
              min_reg     <= min_next;
              max_reg     <= max_next;
              if (win_last) begin
                win_cnt_reg <= '0;
                out_cnt_reg <= out_inc;
                if (res_ok) begin
                  out_vld_reg  <= 1'b1;
                  out_data_reg <= result_next;
                end
                if (frame_end) begin
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= S_IDLE;
                end
              end else begin
                win_cnt_reg <= win_inc;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_out_data = out_data_reg;
  assign o_out_vld  = out_vld_reg;
  assign o_busy     = busy_reg;
  assign o_done     = done_reg;

endmodule

// File: tb/tb_env_acc.sv
// Bench for env_acc: directed scenarios plus randomized frames checked
// against a queue-based window model.
module tb_env_acc;
  localparam int DW = 12, AW = 8, DLW = 16, LW = 12;
  localparam int POSMAX = (1 << (DW - 1)) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_sync;
  logic [DW-1:0]  i_in_data;
  logic           i_in_vld;
  logic [DLW-1:0] i_delay;
  logic [AW-1:0]  i_accum;
  logic [4:0]     i_shift;
  logic [LW-1:0]  i_len;
  logic [2:0]     i_scan_type;
  logic [DW-1:0]  o_out_data;
  logic           o_out_vld;
  logic           o_busy;
  logic           o_done;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [DW-1:0] exp_data;

  always #5 clk = ~clk;

  env_acc #(.DW(DW), .AW(AW), .DLW(DLW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .i_sync(i_sync), .i_in_data(i_in_data),
    .i_in_vld(i_in_vld), .i_delay(i_delay), .i_accum(i_accum),
    .i_shift(i_shift), .i_len(i_len), .i_scan_type(i_scan_type),
    .o_out_data(o_out_data), .o_out_vld(o_out_vld), .o_busy(o_busy),
    .o_done(o_done)
  );

  // One clock: drive inputs, pass the rising edge, settle 1 time unit.
  task automatic cycle(input logic sync, input logic vld, input int data);
    i_sync = sync;
    i_in_vld = vld;
    i_in_data = DW'(data);
    @(posedge clk);
    #1;
    i_sync = 1'b0;
    i_in_vld = 1'b0;
  endtask

  task automatic set_cfg(input int mode, input int delay, input int accum,
                         input int shift, input int len);
    i_scan_type = 3'(mode);
    i_delay = DLW'(delay);
    i_accum = AW'(accum);
    i_shift = 5'(shift);
    i_len = LW'(len);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int rnd_sample();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return -(POSMAX + 1);
    if (r == 1) return POSMAX;
    return int'($urandom_range(0, 2 * POSMAX + 1)) - (POSMAX + 1);
  endfunction

  // Window reduction from the rules, over the full list of window samples.
  function automatic int ref_result(input int mode, input int shift, input int q[$]);
    int best, s, mn, mx, r;
    r = 0;
    case (mode)
      0: begin
        best = q[0];
        foreach (q[i]) if (iabs(q[i]) > iabs(best)) best = q[i];
        r = best;
      end
      1: begin
        s = 0;
        foreach (q[i]) s += iabs(q[i]);
        r = s >> shift;
        if (r > POSMAX) r = POSMAX;
      end
      2: r = q[0];
      3: begin
        mn = q[0];
        mx = q[0];
        foreach (q[i]) begin
          if (q[i] < mn) mn = q[i];
          if (q[i] > mx) mx = q[i];
        end
        r = mx - mn;
        if (r > POSMAX) r = POSMAX;
      end
      4: r = q[q.size() - 1];
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    set_cfg(0, 0, 1, 0, 0);
    cycle(1'b0, 1'b0, 0);
    cycle(1'b1, 1'b1, 5);
    total_cnt++;
    if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", o_busy); else pass_cnt++;
    total_cnt++;
    if (o_out_vld !== 1'b0) $display("FAIL reset_vld: got %b expected 0", o_out_vld); else pass_cnt++;
    total_cnt++;
    if (o_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", o_done); else pass_cnt++;
    total_cnt++;
    if (o_out_data !== '0) $display("FAIL reset_data: got %0d expected 0", $signed(o_out_data)); else pass_cnt++;
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 7);
    total_cnt++;
    if (o_busy !== 1'b0 || o_out_vld !== 1'b0)
      $display("FAIL idle_ignore: got busy=%b vld=%b expected 0 0", o_busy, o_out_vld);
    else pass_cnt++;
  endtask

  task automatic test_max_delay();
    int smp[6] = '{5, 9, -3, 7, -100, 2};
    set_cfg(0, 2, 4, 0, 1);
    cycle(1'b1, 1'b0, 0);
    total_cnt++;
    if (o_busy !== 1'b1) $display("FAIL max_busy: got %b expected 1", o_busy); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, smp[i]);
      total_cnt++;
      if (o_out_vld !== (i == 5)) $display("FAIL max_vld[%0d]: got %b expected %b", i, o_out_vld, (i == 5));
      else pass_cnt++;
    end
    exp_data = DW'(-100);
    total_cnt++;
    if (o_out_data !== exp_data) $display("FAIL max_data: got %0d expected -100", $signed(o_out_data)); else pass_cnt++;
    total_cnt++;
    if (o_done !== 1'b1 || o_busy !== 1'b0)
      $display("FAIL max_done: got done=%b busy=%b expected 1 0", o_done, o_busy);
    else pass_cnt++;
    cycle(1'b0, 1'b1, 50);
    total_cnt++;
    if (o_out_vld !== 1'b0 || o_done !== 1'b0 || o_out_data !== exp_data)
      $display("FAIL max_hold: got vld=%b done=%b data=%0d expected 0 0 -100", o_out_vld, o_done, $signed(o_out_data));
    else pass_cnt++;
  endtask

  task automatic test_mean_sat();
    set_cfg(1, 0, 4, 2, 1);
    cycle(1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, -2048);
    exp_data = DW'(POSMAX);
    total_cnt++;
    if (o_out_vld !== 1'b1 || o_out_data !== exp_data)
      $display("FAIL mean_sat: got vld=%b data=%0d expected 1 %0d", o_out_vld, $signed(o_out_data), POSMAX);
    else pass_cnt++;
  endtask

  task automatic test_pp_first_last();
    int modes[3] = '{3, 2, 4};
    int exps[3] = '{2047, 2047, 0};
    int smp[3] = '{2047, -2048, 0};
    for (int m = 0; m < 3; m++) begin
      set_cfg(modes[m], 0, 3, 0, 1);
      cycle(1'b1, 1'b0, 0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, smp[i]);
      exp_data = DW'(exps[m]);
      total_cnt++;
      if (o_out_vld !== 1'b1 || o_out_data !== exp_data)
        $display("FAIL mode%0d_data: got vld=%b data=%0d expected 1 %0d", modes[m], o_out_vld, $signed(o_out_data), exps[m]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(0, 0, 0, 0, 3);
    cycle(1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, i + 1);
      exp_data = DW'(i + 1);
      total_cnt++;
      if (o_out_vld !== 1'b1 || o_out_data !== exp_data || o_done !== (i == 2))
        $display("FAIL b2b[%0d]: got vld=%b data=%0d done=%b expected 1 %0d %b",
                 i, o_out_vld, $signed(o_out_data), o_done, i + 1, (i == 2));
      else pass_cnt++;
    end
    cycle(1'b0, 1'b1, 9);
    total_cnt++;
    if (o_busy !== 1'b0 || o_out_vld !== 1'b0)
      $display("FAIL b2b_end: got busy=%b vld=%b expected 0 0", o_busy, o_out_vld);
    else pass_cnt++;
  endtask

  task automatic test_toggle_sync();
    set_cfg(0, 0, 2, 0, 0);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 4);
    cycle(1'b0, 1'b0, 77);
    total_cnt++;
    if (o_out_vld !== 1'b0) $display("FAIL tog_early: got %b expected 0", o_out_vld); else pass_cnt++;
    cycle(1'b0, 1'b1, -6);
    exp_data = DW'(-6);
    total_cnt++;
    if (o_out_vld !== 1'b1 || o_out_data !== exp_data)
      $display("FAIL tog_data: got vld=%b data=%0d expected 1 -6", o_out_vld, $signed(o_out_data));
    else pass_cnt++;
    cycle(1'b0, 1'b1, 100);
    cycle(1'b1, 1'b1, -500);
    total_cnt++;
    if (o_out_vld !== 1'b0 || o_out_data !== exp_data)
      $display("FAIL sync_cut: got vld=%b data=%0d expected 0 -6", o_out_vld, $signed(o_out_data));
    else pass_cnt++;
    cycle(1'b0, 1'b1, 1);
    total_cnt++;
    if (o_out_vld !== 1'b0) $display("FAIL sync_fresh1: got %b expected 0", o_out_vld); else pass_cnt++;
    cycle(1'b0, 1'b1, -3);
    exp_data = DW'(-3);
    total_cnt++;
    if (o_out_vld !== 1'b1 || o_out_data !== exp_data)
      $display("FAIL sync_fresh2: got vld=%b data=%0d expected 1 -3", o_out_vld, $signed(o_out_data));
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    set_cfg(1, 0, 3, 0, 0);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 10);
    rst_n = 1'b0;
    cycle(1'b1, 1'b1, 20);
    total_cnt++;
    if (o_out_data !== '0 || o_out_vld !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0)
      $display("FAIL rst_mid: got data=%0d vld=%b busy=%b done=%b expected 0 0 0 0",
               $signed(o_out_data), o_out_vld, o_busy, o_done);
    else pass_cnt++;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 30);
      total_cnt++;
      if (o_out_vld !== 1'b0 || o_busy !== 1'b0)
        $display("FAIL rst_after[%0d]: got vld=%b busy=%b expected 0 0", i, o_out_vld, o_busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int m_mode, m_delay, m_n, m_shift, m_len, k, outs, d, r;
    int win[$];
    logic active, vld, sync, exp_vld, exp_done, exp_busy;
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, 0);
    rst_n = 1'b1;
    exp_data = '0;
    exp_busy = 1'b0;
    active = 1'b0;
    m_mode = 0; m_delay = 0; m_n = 1; m_shift = 0; m_len = 0; k = 0; outs = 0;
    for (int f = 0; f < 14; f++) begin
      for (int c = 0; c < 40; c++) begin
        sync = (c == 0) || ($urandom_range(0, 59) == 0);
        vld = ($urandom_range(0, 3) != 0);
        d = rnd_sample();
        set_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 13)), int'($urandom_range(0, 4)));
        exp_vld = 1'b0;
        exp_done = 1'b0;
        if (sync) begin
          m_mode = int'(i_scan_type);
          m_delay = int'(i_delay);
          m_n = (i_accum == '0) ? 1 : int'(i_accum);
          m_shift = int'(i_shift);
          m_len = int'(i_len);
          k = 0;
          outs = 0;
          win.delete();
          active = 1'b1;
          exp_busy = 1'b1;
        end else if (active && vld) begin
          k++;
          if (k > m_delay) begin
            win.push_back(d);
            if (win.size() == m_n) begin
              r = ref_result(m_mode, m_shift, win);
              if (m_mode <= 4) begin
                exp_vld = 1'b1;
                exp_data = DW'(r);
              end
              outs++;
              if (m_len != 0 && outs == m_len) begin
                exp_done = 1'b1;
                exp_busy = 1'b0;
                active = 1'b0;
              end
              win.delete();
            end
          end
        end
        cycle(sync, vld, d);
        total_cnt++;
        if (o_out_vld !== exp_vld) $display("FAIL rnd_vld f%0d c%0d: got %b expected %b", f, c, o_out_vld, exp_vld);
        else pass_cnt++;
        total_cnt++;
        if (o_out_data !== exp_data)
          $display("FAIL rnd_data f%0d c%0d mode %0d: got %0d expected %0d", f, c, m_mode, $signed(o_out_data), $signed(exp_data));
        else pass_cnt++;
        total_cnt++;
        if (o_done !== exp_done) $display("FAIL rnd_done f%0d c%0d: got %b expected %b", f, c, o_done, exp_done);
        else pass_cnt++;
        total_cnt++;
        if (o_busy !== exp_busy) $display("FAIL rnd_busy f%0d c%0d: got %b expected %b", f, c, o_busy, exp_busy);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_sync = 1'b0;
    i_in_vld = 1'b0;
    i_in_data = '0;
    exp_data = '0;
    set_cfg(0, 0, 1, 0, 0);
    test_reset();
    test_max_delay();
    test_mean_sat();
    test_pp_first_last();
    test_back_to_back();
    test_toggle_sync();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/env_acc.md
ENV_ACC -- requirements
Module: env_acc

Interface
REQ-001 Parameter DW, default 12: sample and result width, signed two's complement.
REQ-002 Parameter AW, default 8: window-length counter width; SW = DW+AW is the internal sum width.
REQ-003 Parameter DLW, default 16: delay counter width.
REQ-004 Parameter LW, default 12: frame-length (output count) width.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 i_sync  in  1  frame start pulse; samples i_delay, i_accum, i_shift, i_len, i_scan_type.
REQ-008 i_in_data  in  DW  signed input sample.
REQ-009 i_in_vld  in  1  i_in_data valid this cycle; only valid samples are counted.
REQ-010 i_delay  in  DLW  number of valid samples discarded after sync.
REQ-011 i_accum  in  AW  window length N in valid samples; 0 treated as 1.
REQ-012 i_shift  in  5  right-shift applied to the MEAN sum.
REQ-013 i_len  in  LW  windows per frame; 0 = unlimited.
REQ-014 i_scan_type  in  3  0 MAX, 1 MEAN, 2 FIRST, 3 PP (peak-to-peak), 4 LAST; 5-7 reserved.
REQ-015 o_out_data  out  DW  signed window result.
REQ-016 o_out_vld  out  1  one-cycle strobe, o_out_data valid.
REQ-017 o_busy  out  1  high from cycle after i_sync until frame ends.
REQ-018 o_done  out  1  one-cycle pulse when the i_len-th window is emitted.

Function
REQ-019 FSM states: IDLE, DELAY, ACCUM; i_sync from any state loads config registers, clears all counters/accumulators and enters DELAY (or ACCUM when i_delay=0).
REQ-020 The sample presented in the i_sync cycle is not accepted.
REQ-021 DELAY: each valid sample increments delay counter; the i_delay-th valid sample is discarded and state moves to ACCUM; the next valid sample is the first window sample.
REQ-022 ACCUM: window counter counts valid samples 1..N; invalid cycles hold all state.
REQ-023 MAX: result = sample with largest |x| in window; ties keep the earlier sample; sign preserved.
REQ-024 MEAN: sum of |x| over window in SW bits, result = sum >> i_shift, saturated to 2^(DW-1)-1.
REQ-025 FIRST: result = first valid sample of window; LAST: result = N-th sample.
REQ-026 PP: result = max(x) - min(x) computed in DW+1 bits, saturated to 2^(DW-1)-1.
REQ-027 |x| computed as DW-bit unsigned; |-2^(DW-1)| = 2^(DW-1) exactly, no wrap.
REQ-028 Reserved modes: windows counted, o_out_vld never asserted, o_done still honoured.
REQ-029 o_out_vld and o_out_data asserted exactly one clk after the cycle accepting the N-th window sample; o_out_data holds until the next result.
REQ-030 Next window starts with the following valid sample; back-to-back windows with N=1 yield o_out_vld on consecutive cycles.
REQ-031 Output counter increments per emitted window; when it equals i_len (nonzero), o_done pulses together with that o_out_vld, o_busy drops the same cycle, state goes IDLE.
REQ-032 i_sync during ACCUM discards the partial window; no output for it.
REQ-033 i_sync coincident with a completing window: the window output is suppressed, restart wins.
REQ-034 In IDLE, samples ignored, outputs hold, o_out_vld low.
REQ-035 Config inputs changing mid-frame have no effect until next i_sync.

Reset
REQ-036 rst_n low at a clock edge: state IDLE, all counters/accumulators 0, o_out_data 0, o_out_vld 0, o_busy 0, o_done 0.
REQ-037 rst_n low overrides a simultaneous i_sync; reset mid-frame drops any pending window.

Verification
REQ-038 MAX, delay 2, N=4, len 1, samples 5,9,-3,7,-100,2 (all valid) -> one o_out_vld with -100 one clk after sample 2, o_done same cycle.
REQ-039 MEAN, N=4, shift 2, samples -2048,-2048,-2048,-2048 -> 2047 (saturated, sum 8192>>2=2048).
REQ-040 PP, N=3, samples 2047,-2048,0 -> 2047 saturated; FIRST same data -> 2047; LAST -> 0.
REQ-041 N=0, len 3, continuous valid samples 1,2,3 -> o_out_vld three consecutive cycles with 1,2,3, o_done on third, o_busy low after.
REQ-042 i_in_vld toggling 1,0,1,0,... N=2 MAX samples 4,x,-6 -> result -6 one clk after the second valid sample; i_sync asserted mid-window -> no output, fresh window.
REQ-043 rst_n low during ACCUM with i_sync high -> all outputs 0 next cycle, state IDLE, subsequent samples ignored.
